// File: rtl/matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_driver
//  Purpose  : HUB75 scan sequencer; fetches pixels column by column, shifts one
//             bit-plane per pass and shows it with binary-coded modulation.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_scan_driver #(
    parameter int COL_BITS       = 6,
    parameter int ROW_BITS       = 4,
    parameter int LOAD_CYCLES    = 5,
    parameter int BASE_OE_CYCLES = 8
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                enable,
    output logic [COL_BITS-1:0] column_address,
    output logic [ROW_BITS-1:0] row_address,
    output logic                pixel_load_start,
    input  logic [15:0]         rgb565_top,
    input  logic [15:0]         rgb565_bottom,
    output logic [2:0]          panel_rgb1,
    output logic [2:0]          panel_rgb2,
    output logic                panel_clk,
    output logic                panel_latch,
    output logic                panel_oe_n,
    output logic [ROW_BITS-1:0] panel_row,
    output logic                frame_start
);

    localparam int c_LOAD_W = $clog2(LOAD_CYCLES);
    localparam int c_OE_W   = $clog2(BASE_OE_CYCLES << 5) + 1;

    localparam logic [c_LOAD_W-1:0] c_LOAD_LAST = c_LOAD_W'(LOAD_CYCLES - 1);
    localparam logic [c_OE_W-1:0]   c_OE_BASE   = c_OE_W'(BASE_OE_CYCLES);
    localparam logic [2:0]          c_LAST_PLANE = 3'd5;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LOAD     = 3'd1;
    localparam logic [2:0] c_ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] c_ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] c_ST_LATCH    = 3'd4;
    localparam logic [2:0] c_ST_DISPLAY  = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          r_plane;
    logic [ROW_BITS-1:0] r_row;
    logic [COL_BITS-1:0] r_col;
    logic [c_LOAD_W-1:0] r_load_cnt;
    logic [c_OE_W-1:0]   r_oe_cnt;

    logic [c_OE_W-1:0]   w_oe_last;
    logic                w_last_plane;
    logic [2:0]          w_plane_next;
    logic [ROW_BITS-1:0] w_row_next;

    // Plane 0 carries only the extra green LSB; red/blue start at plane 1.
    function automatic logic [2:0] plane_bits(input logic [15:0] px, input logic [2:0] p);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        logic       r;
        logic       g;
        logic       b;
        r5 = px[15:11];
        g6 = px[10:5];
        b5 = px[4:0];
        g  = g6[p];
        r  = (p == 3'd0) ? 1'b0 : r5[p - 3'd1];
        b  = (p == 3'd0) ? 1'b0 : b5[p - 3'd1];
        return {b, g, r};
    endfunction

    assign column_address = r_col;
    assign row_address    = r_row;

    assign w_oe_last    = (c_OE_BASE << r_plane) - c_OE_W'(1);
    assign w_last_plane = (r_plane == c_LAST_PLANE);
    assign w_plane_next = w_last_plane ? 3'd0 : r_plane + 3'd1;
    assign w_row_next   = w_last_plane ? r_row + ROW_BITS'(1) : r_row;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state          <= c_ST_IDLE;
            r_plane          <= 3'd0;
            r_row            <= '0;
            r_col            <= '0;
            r_load_cnt       <= '0;
            r_oe_cnt         <= '0;
            pixel_load_start <= 1'b0;
            panel_rgb1       <= 3'd0;
            panel_rgb2       <= 3'd0;
            panel_clk        <= 1'b0;
            panel_latch      <= 1'b0;
            panel_oe_n       <= 1'b1;
            panel_row        <= '0;
            frame_start      <= 1'b0;
        end else begin
            pixel_load_start <= 1'b0;
            frame_start      <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (enable) begin
                        r_state          <= c_ST_LOAD;
                        r_col            <= '0;
                        r_load_cnt       <= '0;
                        pixel_load_start <= 1'b1;
                        frame_start      <= (r_row == '0) && (r_plane == 3'd0);
                    end
                end
                c_ST_LOAD: begin
                    // Fetch data is only trusted on the final wait cycle.
                    if (r_load_cnt == c_LOAD_LAST) begin
                        panel_rgb1 <= plane_bits(rgb565_top, r_plane);
                        panel_rgb2 <= plane_bits(rgb565_bottom, r_plane);
                        r_state    <= c_ST_SHIFT_LO;
                    end else begin
                        r_load_cnt <= r_load_cnt + c_LOAD_W'(1);
                    end
                end
                c_ST_SHIFT_LO: begin
                    panel_clk <= 1'b1;
                    r_state   <= c_ST_SHIFT_HI;
                end
                c_ST_SHIFT_HI: begin
                    panel_clk <= 1'b0;
                    if (r_col == '1) begin
                        panel_latch <= 1'b1;
                        panel_row   <= r_row;
                        r_state     <= c_ST_LATCH;
                    end else begin
                        r_col            <= r_col + COL_BITS'(1);
                        r_load_cnt       <= '0;
                        pixel_load_start <= 1'b1;
                        r_state          <= c_ST_LOAD;
                    end
                end
                c_ST_LATCH: begin
                    panel_latch <= 1'b0;
                    panel_oe_n  <= 1'b0;
                    r_oe_cnt    <= '0;
                    r_state     <= c_ST_DISPLAY;
                end
                c_ST_DISPLAY: begin
                    if (r_oe_cnt == w_oe_last) begin
                        panel_oe_n <= 1'b1;
                        r_plane    <= w_plane_next;
                        r_row      <= w_row_next;
                        // enable is only honoured here and in IDLE, at pass boundaries.
                        if (enable) begin
                            r_state          <= c_ST_LOAD;
                            r_col            <= '0;
                            r_load_cnt       <= '0;
                            pixel_load_start <= 1'b1;
                            frame_start      <= (w_row_next == '0) && (w_plane_next == 3'd0);
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_oe_cnt <= r_oe_cnt + c_OE_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_scan_driver
//  Purpose  : Self-checking bench for matrix_scan_driver against a pass-level
//             reference model of the scan order and plane-bit extraction.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_scan_driver;

    logic        clk_in;
    logic        reset;
    logic        enable;
    logic [5:0]  column_address;
    logic [3:0]  row_address;
    logic        pixel_load_start;
    logic [15:0] rgb565_top;
    logic [15:0] rgb565_bottom;
    logic [2:0]  panel_rgb1;
    logic [2:0]  panel_rgb2;
    logic        panel_clk;
    logic        panel_latch;
    logic        panel_oe_n;
    logic [3:0]  panel_row;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fb_top [16][64];
    logic [15:0] fb_bot [16][64];
    logic [15:0] junk = 16'h0;
    int          lat  = 0;
    logic [2:0]  cap1 [64];
    logic [2:0]  cap2 [64];

    typedef struct {
        logic [15:0] top;
        logic [15:0] bot;
        int          plane;
        logic [2:0]  rgb1;
        logic [2:0]  rgb2;
    } vec_t;
    vec_t tbl [8];

    matrix_scan_driver dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .enable           (enable),
        .column_address   (column_address),
        .row_address      (row_address),
        .pixel_load_start (pixel_load_start),
        .rgb565_top       (rgb565_top),
        .rgb565_bottom    (rgb565_bottom),
        .panel_rgb1       (panel_rgb1),
        .panel_rgb2       (panel_rgb2),
        .panel_clk        (panel_clk),
        .panel_latch      (panel_latch),
        .panel_oe_n       (panel_oe_n),
        .panel_row        (panel_row),
        .frame_start      (frame_start)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Fetch model: garbage for a few cycles after each strobe, then the framebuffer word.
    always @(posedge clk_in) begin
        junk <= 16'($urandom);
        if (pixel_load_start) lat <= 1;
        else if (lat < 7) lat <= lat + 1;
    end
    assign rgb565_top    = (pixel_load_start || lat < 3) ? junk : fb_top[row_address][column_address];
    assign rgb565_bottom = (pixel_load_start || lat < 3) ? ~junk : fb_bot[row_address][column_address];

    function automatic logic [2:0] exp_bits(input logic [15:0] px, input int p);
        int r5, g6, b5, rb, gb, bb;
        r5 = int'(px[15:11]);
        g6 = int'(px[10:5]);
        b5 = int'(px[4:0]);
        gb = (g6 >> p) & 1;
        rb = (p == 0) ? 0 : ((r5 >> (p - 1)) & 1);
        bb = (p == 0) ? 0 : ((b5 >> (p - 1)) & 1);
        return 3'(bb * 4 + gb * 2 + rb);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full pass: strobes, 64 shifted columns, latch, weighted display.
    task automatic run_pass(input int exp_row, input int exp_plane, input bit exp_fs,
                            input bit drop_en, input bit rst_in_disp);
        int cyc, edges, pls, viol, bad, lo;
        bit pc;
        cyc = 0;
        while (!pixel_load_start && cyc < 3000) begin
            @(negedge clk_in);
            cyc++;
        end
        check("pass_start_seen", int'(pixel_load_start), 1);
        check("frame_start", int'(frame_start), int'(exp_fs));
        check("first_row_address", int'(row_address), exp_row);
        check("first_column_address", int'(column_address), 0);
        cyc = 0; edges = 0; pls = 1; viol = 0; bad = 0; pc = panel_clk;
        while (cyc < 1000) begin
            @(negedge clk_in);
            cyc++;
            if (pixel_load_start) pls++;
            if (panel_clk && panel_latch) viol++;
            if (!panel_oe_n) viol++;
            if (frame_start) viol++;
            if (panel_clk && !pc) begin
                if (edges < 64) begin
                    cap1[edges] = panel_rgb1;
                    cap2[edges] = panel_rgb2;
                    if (column_address != 6'(edges) ||
                        panel_rgb1 != exp_bits(fb_top[4'(exp_row)][6'(edges)], exp_plane) ||
                        panel_rgb2 != exp_bits(fb_bot[4'(exp_row)][6'(edges)], exp_plane))
                        bad++;
                end
                edges++;
                if (edges == 10 && drop_en) enable = 1'b0;
            end
            pc = panel_clk;
            if (panel_latch) break;
        end
        check("latch_seen", int'(panel_latch), 1);
        check("shift_cycles", cyc, 448);
        check("panel_clk_edges", edges, 64);
        check("load_strobes", pls, 64);
        check("pixel_bit_errors", bad, 0);
        check("protocol_violations", viol, 0);
        check("panel_row", int'(panel_row), exp_row);
        @(negedge clk_in);
        check("latch_width", int'(panel_latch), 0);
        lo = 0;
        while (!panel_oe_n && lo < 600) begin
            if (rst_in_disp && lo == 4) begin
                reset = 1'b1;
                #1;
                check("rst_oe_n", int'(panel_oe_n), 1);
                check("rst_load_start", int'(pixel_load_start), 0);
                check("rst_panel_row", int'(panel_row), 0);
                check("rst_clk_latch", int'({panel_clk, panel_latch}), 0);
                return;
            end
            lo++;
            @(negedge clk_in);
        end
        check("oe_low_cycles", lo, 8 << exp_plane);
    endtask

    initial begin
        int bad;
        reset  = 1'b1;
        enable = 1'b0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 64; c++) begin
                fb_top[r][c] = 16'($urandom);
                fb_bot[r][c] = 16'($urandom);
            end
        tbl[0] = '{16'hF800, 16'h07E0, 5, 3'b001, 3'b010};
        tbl[1] = '{16'hF800, 16'h07E0, 0, 3'b000, 3'b010};
        tbl[2] = '{16'h001F, 16'h0000, 1, 3'b100, 3'b000};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 0, 3'b010, 3'b010};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 3, 3'b111, 3'b111};
        tbl[5] = '{16'h0020, 16'h0800, 0, 3'b010, 3'b000};
        tbl[6] = '{16'h0020, 16'h0800, 1, 3'b000, 3'b001};
        tbl[7] = '{16'h0400, 16'h0010, 5, 3'b010, 3'b100};
        for (int i = 0; i < 8; i++) begin
            fb_top[0][i] = tbl[i].top;
            fb_bot[0][i] = tbl[i].bot;
        end

        repeat (3) @(negedge clk_in);
        check("reset_oe_n", int'(panel_oe_n), 1);
        check("reset_strobes", int'({pixel_load_start, panel_clk, panel_latch, frame_start}), 0);
        check("reset_addresses", int'({column_address, row_address, panel_row}), 0);
        check("reset_rgb", int'({panel_rgb1, panel_rgb2}), 0);
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (pixel_load_start || !panel_oe_n || panel_clk || panel_latch || frame_start) bad++;
        end
        check("idle_activity", bad, 0);

        enable = 1'b1;
        for (int n = 0; n < 97; n++) begin
            run_pass((n / 6) % 16, n % 6, (n % 96) == 0, n == 20, 1'b0);
            if (n < 6)
                for (int i = 0; i < 8; i++)
                    if (tbl[i].plane == n) begin
                        check($sformatf("tbl%0d_rgb1", i), int'(cap1[i]), int'(tbl[i].rgb1));
                        check($sformatf("tbl%0d_rgb2", i), int'(cap2[i]), int'(tbl[i].rgb2));
                    end
            if (n == 20) begin
                bad = 0;
                for (int i = 0; i < 50; i++) begin
                    if (pixel_load_start || !panel_oe_n || panel_latch) bad++;
                    @(negedge clk_in);
                end
                check("idle_after_drop", bad, 0);
                enable = 1'b1;
            end
        end

        run_pass(0, 1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        run_pass(0, 0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
